mem_access_unit: RTL and testbench

- Initiator side of the data memory interface, sitting in the MEM stage of the pipeline between the EX/MEM register and data_memory.
- Accepts byte-addressed load/store requests from the pipeline and issues only full-word, word-indexed accesses to data_memory.
- Performs lane extraction with sign/zero extension for loads, and read-modify-write for byte and halfword stores.
- Drives a stall (busy) signal back to the pipeline while a request is outstanding.

---
 rtl/mem_access_pkg.sv | 42 ++++
 rtl/mem_access_unit_if.sv | 37 +++
 rtl/mem_access_unit_align.sv | 59 +++++
 rtl/mem_access_unit.sv | 135 +++++++++++++
 tb/tb_mem_access_unit.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage data memory initiator: request sizes,
// FSM state codes and the fixed word-mode size_control value.
package mem_access_pkg;

    localparam logic [1:0] BYTE = 2'b01;
    localparam logic [1:0] HALF = 2'b10;
    localparam logic [1:0] WORD = 2'b00;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WR        = 3'd1;
    localparam logic [2:0] ST_RD        = 3'd2;
    localparam logic [2:0] ST_RD_DATA   = 3'd3;
    localparam logic [2:0] ST_RMW_RD    = 3'd4;
    localparam logic [2:0] ST_RMW_MERGE = 3'd5;
    localparam logic [2:0] ST_RMW_WR    = 3'd6;
    localparam logic [2:0] ST_ERR       = 3'd7;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        WR        = ST_WR,
        RD        = ST_RD,
        RD_DATA   = ST_RD_DATA,
        RMW_RD    = ST_RMW_RD,
        RMW_MERGE = ST_RMW_MERGE,
        RMW_WR    = ST_RMW_WR,
        ERR       = ST_ERR
    } state_t;

    localparam logic [5:0] WORD_MODE = 6'b000000;

    // Encodings 00 and 11 both mean a full word, so anything that is not a
    // byte or half must sit on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        if (size == BYTE)
            return 1'b0;
        else if (size == HALF)
            return offset[0];
        else
            return (offset != 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle of pipeline request/response and data_memory signals for mem_access_unit.
interface mem_access_unit_if #(
    parameter int ADDR_LENGTH = 32,
    parameter int DATA_LENGTH = 32
);
    logic                   i_req_valid;
    logic                   i_req_we;
    logic                   i_req_re;
    logic [ADDR_LENGTH-1:0] i_addr;
    logic [1:0]             i_size;
    logic                   i_unsigned;
    logic [DATA_LENGTH-1:0] i_wdata;
    logic                   o_busy;
    logic                   o_done;
    logic [DATA_LENGTH-1:0] o_rdata;
    logic                   o_misaligned;
    logic [ADDR_LENGTH-1:0] o_mem_addr;
    logic                   o_mem_we;
    logic                   o_mem_re;
    logic [5:0]             o_mem_size;
    logic [DATA_LENGTH-1:0] o_mem_wdata;
    logic [DATA_LENGTH-1:0] i_mem_rdata;

    modport slave (
        input  i_req_valid, i_req_we, i_req_re, i_addr, i_size, i_unsigned, i_wdata,
        input  i_mem_rdata,
        output o_busy, o_done, o_rdata, o_misaligned,
        output o_mem_addr, o_mem_we, o_mem_re, o_mem_size, o_mem_wdata
    );

    modport master (
        output i_req_valid, i_req_we, i_req_re, i_addr, i_size, i_unsigned, i_wdata,
        output i_mem_rdata,
        input  o_busy, o_done, o_rdata, o_misaligned,
        input  o_mem_addr, o_mem_we, o_mem_re, o_mem_size, o_mem_wdata
    );
endinterface

// File: rtl/mem_access_unit_align.sv
// Little-endian lane logic: extracts and extends load lanes, and merges store
// lanes into an existing word for read-modify-write.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] load_word,
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] load_value,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        fill;

    always_comb begin
        byte_lane = 8'h00;
        half_lane = offset[1] ? load_word[31:16] : load_word[15:0];
        case (offset)
            2'd0:    byte_lane = load_word[7:0];
            2'd1:    byte_lane = load_word[15:8];
            2'd2:    byte_lane = load_word[23:16];
            default: byte_lane = load_word[31:24];
        endcase

        fill       = 1'b0;
        load_value = load_word;
        if (size == BYTE) begin
            fill       = ~is_unsigned & byte_lane[7];
            load_value = {{24{fill}}, byte_lane};
        end else if (size == HALF) begin
            fill       = ~is_unsigned & half_lane[15];
            load_value = {{16{fill}}, half_lane};
        end
    end

    // Only the addressed lane is replaced; word-size stores never come through here.
    always_comb begin
        merged_word = old_word;
        if (size == BYTE) begin
            case (offset)
                2'd0:    merged_word[7:0]   = new_data[7:0];
                2'd1:    merged_word[15:8]  = new_data[7:0];
                2'd2:    merged_word[23:16] = new_data[7:0];
                default: merged_word[31:24] = new_data[7:0];
            endcase
        end else if (size == HALF) begin
            if (offset[1])
                merged_word[31:16] = new_data[15:0];
            else
                merged_word[15:0]  = new_data[15:0];
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: turns byte-addressed load/store requests into word-only
// data_memory accesses, with lane extension on loads and RMW for subword stores.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_LENGTH = 32,
    parameter int DATA_LENGTH = 32,
    parameter int MEM_SIZE    = 1024
) (
    input logic              i_clk,
    input logic              i_rst,
    mem_access_unit_if.slave bus
);

    // MEM_SIZE only matters to data_memory; an empty memory is not a usable build.
    if (MEM_SIZE < 1) begin : g_mem_size_guard
    end

    state_t                 state;
    logic [ADDR_LENGTH-1:0] addr;
    logic [1:0]             size;
    logic                   is_unsigned;
    logic [DATA_LENGTH-1:0] wdata;
    logic                   done;
    logic                   misaligned;
    logic [DATA_LENGTH-1:0] rdata;
    logic [ADDR_LENGTH-1:0] mem_addr;
    logic                   mem_we;
    logic                   mem_re;
    logic [DATA_LENGTH-1:0] mem_wdata;
    logic [DATA_LENGTH-1:0] load_value;
    logic [DATA_LENGTH-1:0] merged_word;
    logic                   accept;
    logic                   subword;

    assign accept  = (state == IDLE) && bus.i_req_valid && (bus.i_req_we || bus.i_req_re);
    assign subword = (bus.i_size == BYTE) || (bus.i_size == HALF);

    mem_lane_align u_align (
        .load_word   (bus.i_mem_rdata),
        .old_word    (bus.i_mem_rdata),
        .new_data    (wdata),
        .offset      (addr[1:0]),
        .size        (size),
        .is_unsigned (is_unsigned),
        .load_value  (load_value),
        .merged_word (merged_word)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            addr        <= '0;
            size        <= WORD;
            is_unsigned <= 1'b0;
            wdata       <= '0;
            done        <= 1'b0;
            misaligned  <= 1'b0;
            rdata       <= '0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_re      <= 1'b0;
            mem_wdata   <= '0;
        end else begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            case (state)
                IDLE: begin
                    // Decisions here use the live request; the latched copy serves later states.
                    if (accept) begin
                        addr        <= bus.i_addr;
                        size        <= bus.i_size;
                        is_unsigned <= bus.i_unsigned;
                        wdata       <= bus.i_wdata;
                        mem_addr    <= bus.i_addr >> 2;
                        if (is_misaligned(bus.i_size, bus.i_addr[1:0])) begin
                            state      <= ERR;
                            done       <= 1'b1;
                            misaligned <= 1'b1;
                        end else if (bus.i_req_we && subword) begin
                            state  <= RMW_RD;
                            mem_re <= 1'b1;
                        end else if (bus.i_req_we) begin
                            state     <= WR;
                            mem_we    <= 1'b1;
                            mem_wdata <= bus.i_wdata;
                        end else begin
                            state  <= RD;
                            mem_re <= 1'b1;
                        end
                    end
                end
                WR: begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                RD:
                    state <= RD_DATA;
                RD_DATA: begin
                    rdata <= load_value;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                RMW_RD:
                    state <= RMW_MERGE;
                RMW_MERGE: begin
                    mem_wdata <= merged_word;
                    mem_we    <= 1'b1;
                    state     <= RMW_WR;
                end
                RMW_WR: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                ERR:
                    state <= IDLE;
                default:
                    state <= IDLE;
            endcase
        end
    end

    assign bus.o_busy       = (state != IDLE);
    assign bus.o_done       = done;
    assign bus.o_misaligned = misaligned;
    assign bus.o_rdata      = rdata;
    assign bus.o_mem_addr   = mem_addr;
    assign bus.o_mem_we     = mem_we;
    assign bus.o_mem_re     = mem_re;
    assign bus.o_mem_size   = WORD_MODE;
    assign bus.o_mem_wdata  = mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word-wide data_memory model that
// writes on negedge and returns read data registered on posedge.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [31:0] mem [0:1023];

    mem_access_unit_if #(.ADDR_LENGTH(32), .DATA_LENGTH(32)) bus ();

    mem_access_unit #(.ADDR_LENGTH(32), .DATA_LENGTH(32), .MEM_SIZE(1024)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (bus.o_mem_we) mem[bus.o_mem_addr[9:0]] <= bus.o_mem_wdata;

    always @(posedge clk)
        if (bus.o_mem_re) bus.i_mem_rdata <= mem[bus.o_mem_addr[9:0]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic we, input logic re, input logic [31:0] addr,
                                  input logic [1:0] size, input logic uns, input logic [31:0] wdata);
        bus.i_req_valid = 1'b1;
        bus.i_req_we    = we;
        bus.i_req_re    = re;
        bus.i_addr      = addr;
        bus.i_size      = size;
        bus.i_unsigned  = uns;
        bus.i_wdata     = wdata;
    endtask

    task automatic clear_request();
        bus.i_req_valid = 1'b0;
        bus.i_req_we    = 1'b0;
        bus.i_req_re    = 1'b0;
    endtask

    // Issue a request and wait (bounded) for its done pulse.
    task automatic run_request(input string tag, input logic we, input logic [31:0] addr,
                               input logic [1:0] size, input logic uns, input logic [31:0] wdata);
        apply_stimulus(we, ~we, addr, size, uns, wdata);
        tick();
        clear_request();
        for (int i = 0; i < 8 && !bus.o_done; i++) tick();
        check_output({tag, "_done"}, {31'b0, bus.o_done}, 32'd1);
    endtask

    task automatic run_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic uns, input logic [31:0] expected);
        run_request(tag, 1'b0, addr, size, uns, 32'h0);
        check_output(tag, bus.o_rdata, expected);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.i_mem_rdata = 32'h0;
        bus.i_addr      = 32'h0;
        bus.i_size      = WORD;
        bus.i_unsigned  = 1'b0;
        bus.i_wdata     = 32'h0;
        clear_request();
        tick();
        tick();

        check_output("rst_busy",  {31'b0, bus.o_busy}, 32'd0);
        check_output("rst_done",  {31'b0, bus.o_done}, 32'd0);
        check_output("rst_we_re", {30'b0, bus.o_mem_we, bus.o_mem_re}, 32'd0);
        check_output("rst_mis",   {31'b0, bus.o_misaligned}, 32'd0);
        check_output("rst_rdata", bus.o_rdata, 32'h0);
        check_output("rst_maddr", bus.o_mem_addr, 32'h0);
        check_output("rst_mwdat", bus.o_mem_wdata, 32'h0);
        check_output("mem_size",  {26'b0, bus.o_mem_size}, 32'h0);
        rst = 1'b0;
        tick();

        $display("[TB] word store then load");
        apply_stimulus(1'b1, 1'b0, 32'h10, WORD, 1'b0, 32'hDEADBEEF);
        tick();
        clear_request();
        check_output("sw_we",    {30'b0, bus.o_mem_we, bus.o_mem_re}, 32'd2);
        check_output("sw_addr",  bus.o_mem_addr, 32'd4);
        check_output("sw_wdata", bus.o_mem_wdata, 32'hDEADBEEF);
        check_output("sw_busy",  {31'b0, bus.o_busy}, 32'd1);
        tick();
        check_output("sw_done",  {30'b0, bus.o_done, bus.o_busy}, 32'd2);
        check_output("sw_we_off", {31'b0, bus.o_mem_we}, 32'd0);
        tick();
        apply_stimulus(1'b0, 1'b1, 32'h10, WORD, 1'b0, 32'h0);
        tick();
        clear_request();
        check_output("lw_re",    {30'b0, bus.o_mem_we, bus.o_mem_re}, 32'd1);
        check_output("lw_addr",  bus.o_mem_addr, 32'd4);
        tick();
        check_output("lw_c2",    {29'b0, bus.o_done, bus.o_mem_we, bus.o_mem_re}, 32'd0);
        tick();
        check_output("lw_done",  {31'b0, bus.o_done}, 32'd1);
        check_output("lw_rdata", bus.o_rdata, 32'hDEADBEEF);

        $display("[TB] byte and half loads");
        run_request("pre4", 1'b1, 32'h10, WORD, 1'b0, 32'h80F17F00);
        run_load("lb_13",  32'h13, BYTE, 1'b0, 32'hFFFFFF80);
        run_load("lbu_13", 32'h13, BYTE, 1'b1, 32'h00000080);
        run_load("lb_11",  32'h11, BYTE, 1'b0, 32'h0000007F);
        run_load("lh_12",  32'h12, HALF, 1'b0, 32'hFFFF80F1);
        run_load("lhu_12", 32'h12, HALF, 1'b1, 32'h000080F1);
        run_load("lh_10",  32'h10, HALF, 1'b0, 32'h00007F00);

        $display("[TB] subword store read-modify-write");
        run_request("pre2", 1'b1, 32'h08, WORD, 1'b0, 32'h11223344);
        apply_stimulus(1'b1, 1'b0, 32'h09, BYTE, 1'b0, 32'h000000AA);
        tick();
        clear_request();
        check_output("sb_c1", {30'b0, bus.o_mem_we, bus.o_mem_re}, 32'd1);
        tick();
        check_output("sb_c2", {30'b0, bus.o_mem_we, bus.o_mem_re}, 32'd0);
        tick();
        check_output("sb_c3", {30'b0, bus.o_mem_we, bus.o_mem_re}, 32'd2);
        check_output("sb_wdata", bus.o_mem_wdata, 32'h1122AA44);
        check_output("sb_addr",  bus.o_mem_addr, 32'd2);
        tick();
        check_output("sb_done", {30'b0, bus.o_done, bus.o_mem_we}, 32'd2);
        tick();
        run_request("sh_0a", 1'b1, 32'h0A, HALF, 1'b0, 32'h0000BEEF);
        run_load("lw_08", 32'h08, WORD, 1'b0, 32'hBEEFAA44);

        $display("[TB] misaligned requests");
        apply_stimulus(1'b0, 1'b1, 32'h06, WORD, 1'b0, 32'h0);
        tick();
        clear_request();
        check_output("mis_lw",    {30'b0, bus.o_done, bus.o_misaligned}, 32'd3);
        check_output("mis_lw_st", {30'b0, bus.o_mem_we, bus.o_mem_re}, 32'd0);
        tick();
        check_output("mis_lw_end", {29'b0, bus.o_done, bus.o_misaligned, bus.o_busy}, 32'd0);
        apply_stimulus(1'b0, 1'b1, 32'h05, HALF, 1'b0, 32'h0);
        tick();
        clear_request();
        check_output("mis_lh",    {30'b0, bus.o_done, bus.o_misaligned}, 32'd3);
        check_output("mis_lh_st", {30'b0, bus.o_mem_we, bus.o_mem_re}, 32'd0);
        tick();
        check_output("mis_lh_st2", {30'b0, bus.o_mem_we, bus.o_mem_re}, 32'd0);

        $display("[TB] reset during RMW merge");
        run_request("pre5", 1'b1, 32'h14, WORD, 1'b0, 32'h55667788);
        apply_stimulus(1'b1, 1'b0, 32'h14, BYTE, 1'b0, 32'h00000099);
        tick();
        clear_request();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("rst_rmw_busy", {31'b0, bus.o_busy}, 32'd0);
        check_output("rst_rmw_we",   {31'b0, bus.o_mem_we}, 32'd0);
        tick();
        tick();
        run_load("rst_rmw_mem", 32'h14, WORD, 1'b0, 32'h55667788);

        $display("[TB] back-to-back store and load");
        tick();
        apply_stimulus(1'b1, 1'b0, 32'h20, WORD, 1'b0, 32'hCAFEF00D);
        tick();
        apply_stimulus(1'b0, 1'b1, 32'h20, WORD, 1'b0, 32'h0);
        tick();
        check_output("b2b_done", {30'b0, bus.o_done, bus.o_busy}, 32'd2);
        tick();
        clear_request();
        check_output("b2b_re",   {30'b0, bus.o_mem_we, bus.o_mem_re}, 32'd1);
        check_output("b2b_addr", bus.o_mem_addr, 32'd8);
        tick();
        tick();
        check_output("b2b_ldone", {31'b0, bus.o_done}, 32'd1);
        check_output("b2b_rdata", bus.o_rdata, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
